// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing a single-cycle add/sub/xor ALU between two requesters.
// Define ALU_ARB_STATS_EN to add the per-requester GrantCount0/GrantCount1 counters.
module alu_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clock,
   input  logic             ResetN,
   input  logic             ReqValid0,
   output logic             ReqReady0,
   input  logic [1:0]       ReqOp0,
   input  logic [WIDTH-1:0] ReqA0,
   input  logic [WIDTH-1:0] ReqB0,
   input  logic             ReqValid1,
   output logic             ReqReady1,
   input  logic [1:0]       ReqOp1,
   input  logic [WIDTH-1:0] ReqA1,
   input  logic [WIDTH-1:0] ReqB1,
   output logic             ResultValid,
   input  logic             ResultReady,
   output logic [WIDTH-1:0] Result,
   output logic             ResultZero,
   output logic             ResultId,
   output logic             Busy
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]      GrantCount0,
   output logic [15:0]      GrantCount1
`endif
);

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   state_e           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             id_q, id_d;
   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             res_zero_q, res_zero_d;
   logic             res_id_q, res_id_d;

   logic             grant0, grant1;
   logic [WIDTH-1:0] alu_res;
   logic             alu_zero;

   // Shared ALU, fed only from the latched operands.
   always_comb begin
      case (op_q)
         2'b00:   alu_res = a_q + b_q;
         2'b10:   alu_res = a_q - b_q;
         default: alu_res = a_q ^ b_q;
      endcase
      alu_zero = (op_q == 2'b10) && (alu_res == '0);
   end

   // With both valid, the requester that did not win last time gets the grant.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == StIdle) begin
         if (ReqValid0 && ReqValid1) begin
            grant0 = last_grant_q;
            grant1 = !last_grant_q;
         end else begin
            grant0 = ReqValid0;
            grant1 = ReqValid1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      id_d         = id_q;
      res_valid_d  = res_valid_q;
      res_d        = res_q;
      res_zero_d   = res_zero_q;
      res_id_d     = res_id_q;
      case (state_q)
         StIdle: begin
            if (grant0 || grant1) begin
               state_d      = StExec;
               op_d         = grant1 ? ReqOp1 : ReqOp0;
               a_d          = grant1 ? ReqA1 : ReqA0;
               b_d          = grant1 ? ReqB1 : ReqB0;
               id_d         = grant1;
               last_grant_d = grant1;
            end
         end
         StExec: begin
            res_d       = alu_res;
            res_zero_d  = alu_zero;
            res_id_d    = id_q;
            res_valid_d = 1'b1;
            state_d     = StDone;
         end
         StDone: begin
            if (ResultReady) begin
               res_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         op_q         <= 2'b00;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= 1'b0;
         res_valid_q  <= 1'b0;
         res_q        <= '0;
         res_zero_q   <= 1'b0;
         res_id_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         id_q         <= id_d;
         res_valid_q  <= res_valid_d;
         res_q        <= res_d;
         res_zero_q   <= res_zero_d;
         res_id_q     <= res_id_d;
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   always_comb begin
      cnt0_d = cnt0_q + {15'd0, grant0};
      cnt1_d = cnt1_q + {15'd0, grant1};
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign GrantCount0 = cnt0_q;
   assign GrantCount1 = cnt1_q;
`endif

   // Gated by reset so an asserted ReqValid cannot leak a ready while in reset.
   assign ReqReady0   = grant0 && ResetN;
   assign ReqReady1   = grant1 && ResetN;
   assign ResultValid = res_valid_q;
   assign Result      = res_q;
   assign ResultZero  = res_zero_q;
   assign ResultId    = res_id_q;
   assign Busy        = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the arbitration and arithmetic rules.
module tb_alu_arbiter;

   logic        Clock = 1'b0;
   logic        ResetN;
   logic        ReqValid0, ReqValid1, ReqReady0, ReqReady1;
   logic [1:0]  ReqOp0, ReqOp1;
   logic [31:0] ReqA0, ReqB0, ReqA1, ReqB1;
   logic        ResultValid, ResultReady;
   logic [31:0] Result;
   logic        ResultZero, ResultId, Busy;
`ifdef ALU_ARB_STATS_EN
   logic [15:0] GrantCount0, GrantCount1;
`endif

   int checks = 0;
   int errors = 0;
   int last_win;
   int ng0, ng1;

   always #5 Clock = ~Clock;

   alu_arbiter #(.WIDTH(32)) dut (
      .Clock(Clock), .ResetN(ResetN),
      .ReqValid0(ReqValid0), .ReqReady0(ReqReady0), .ReqOp0(ReqOp0),
      .ReqA0(ReqA0), .ReqB0(ReqB0),
      .ReqValid1(ReqValid1), .ReqReady1(ReqReady1), .ReqOp1(ReqOp1),
      .ReqA1(ReqA1), .ReqB1(ReqB1),
      .ResultValid(ResultValid), .ResultReady(ResultReady), .Result(Result),
      .ResultZero(ResultZero), .ResultId(ResultId), .Busy(Busy)
`ifdef ALU_ARB_STATS_EN
      , .GrantCount0(GrantCount0), .GrantCount1(GrantCount1)
`endif
   );

   // Reference arithmetic: {zero, result}
   function automatic logic [32:0] model_alu(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] r;
      if (op == 2'b00)      r = a + b;
      else if (op == 2'b10) r = a - b;
      else                  r = a ^ b;
      return {(op == 2'b10) && (r == 32'd0), r};
   endfunction

   function automatic int exp_win(input bit v0, input bit v1);
      if (v0 && v1) return 1 - last_win;
      return v0 ? 0 : 1;
   endfunction

   // Drives one request round and returns what the DUT did; never judges it.
   // Returns at a falling edge in the result-holding state with ResultReady high.
   task automatic run_txn(input bit v0, input bit v1, input bit keep, input int bp,
                          output int gid, output logic [31:0] r, output logic z,
                          output logic id, output bit tmo);
      bit seen;
      tmo = 0;
      gid = -1;
      seen = 0;
      r = '0; z = 0; id = 0;
      @(posedge Clock); #1;
      ReqValid0 = v0;
      ReqValid1 = v1;
      ResultReady = (bp == 0);
      for (int i = 0; i < 8 && gid < 0; i++) begin
         @(negedge Clock);
         if (ReqReady0) gid = 0;
         else if (ReqReady1) gid = 1;
      end
      if (gid < 0) begin
         tmo = 1;
      end else begin
         @(posedge Clock); #1;
         if (!keep) begin
            if (gid == 0) ReqValid0 = 0;
            else ReqValid1 = 0;
         end
         for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge Clock);
            seen = ResultValid;
         end
         if (!seen) tmo = 1;
         r = Result; z = ResultZero; id = ResultId;
         repeat (bp) @(negedge Clock);
         ResultReady = 1;
      end
   endtask

   task automatic test_reset;
      ResetN = 0;
      ReqValid0 = 1; ReqValid1 = 1; ResultReady = 0;
      ReqOp0 = 0; ReqOp1 = 0; ReqA0 = 0; ReqB0 = 0; ReqA1 = 0; ReqB1 = 0;
      repeat (2) @(negedge Clock);
      checks++;
      if (ReqReady0 !== 0 || ReqReady1 !== 0) begin
         errors++; $display("FAIL reset_ready: got %b%b required 00", ReqReady0, ReqReady1);
      end
      checks++;
      if (ResultValid !== 0 || Busy !== 0) begin
         errors++; $display("FAIL reset_valid_busy: got %b%b required 00", ResultValid, Busy);
      end
      checks++;
      if (Result !== 32'd0 || ResultZero !== 0 || ResultId !== 0) begin
         errors++;
         $display("FAIL reset_result: got %h z%b id%b required 0", Result, ResultZero, ResultId);
      end
`ifdef ALU_ARB_STATS_EN
      checks++;
      if (GrantCount0 !== 16'd0 || GrantCount1 !== 16'd0) begin
         errors++; $display("FAIL reset_counts: got %h %h required 0", GrantCount0, GrantCount1);
      end
`endif
      ReqValid0 = 0; ReqValid1 = 0;
      ResetN = 1;
      last_win = 1;
   endtask

   task automatic test_req0_add;
      @(posedge Clock); #1;
      ReqOp0 = 2'b00; ReqA0 = 12; ReqB0 = 4; ReqValid0 = 1; ResultReady = 1;
      @(negedge Clock);
      checks++;
      if (ReqReady0 !== 1 || ReqReady1 !== 0) begin
         errors++; $display("FAIL req0_grant: got %b%b required 10", ReqReady0, ReqReady1);
      end
      @(posedge Clock); #1;
      ReqValid0 = 0;
      @(negedge Clock);
      checks++;
      if (ReqReady0 !== 0 || Busy !== 1 || ResultValid !== 0) begin
         errors++;
         $display("FAIL req0_exec: got rdy%b busy%b val%b required 010", ReqReady0, Busy,
                  ResultValid);
      end
      @(negedge Clock);
      checks++;
      if (ResultValid !== 1 || Result !== 32'd16 || ResultZero !== 0 || ResultId !== 0) begin
         errors++;
         $display("FAIL req0_result: got v%b %h z%b id%b required v1 00000010 z0 id0",
                  ResultValid, Result, ResultZero, ResultId);
      end
      @(negedge Clock);
      checks++;
      if (ResultValid !== 0 || Busy !== 0) begin
         errors++; $display("FAIL req0_idle: got v%b busy%b required 00", ResultValid, Busy);
      end
      last_win = 0;
   endtask

   task automatic test_req1_sub;
      logic [1:0]  ops [3] = '{2'b10, 2'b10, 2'b00};
      logic [31:0] as  [3] = '{32'd20, 32'd5, 32'd0};
      logic [31:0] bs  [3] = '{32'd14, 32'd5, 32'd0};
      int gid; logic [31:0] r; logic z, id; bit tmo; logic [32:0] e;
      for (int i = 0; i < 3; i++) begin
         ReqOp1 = ops[i]; ReqA1 = as[i]; ReqB1 = bs[i];
         e = model_alu(ops[i], as[i], bs[i]);
         run_txn(0, 1, 0, 0, gid, r, z, id, tmo);
         checks++;
         if (tmo || gid != 1 || r !== e[31:0] || z !== e[32] || id !== 1) begin
            errors++;
            $display("FAIL req1_op%0d: got gnt%0d %h z%b id%b tmo%b required gnt1 %h z%b id1",
                     i, gid, r, z, id, tmo, e[31:0], e[32]);
         end
         last_win = 1;
      end
   endtask

   task automatic test_both_rr;
      int gid, w; logic [31:0] r; logic z, id; bit tmo; logic [32:0] e;
      ReqOp0 = 2'b01; ReqA0 = 32'hF0F0F0F0; ReqB0 = 32'h0F0F0F0F;
      ReqOp1 = 2'b01; ReqA1 = 32'hAAAAAAAA; ReqB1 = 32'hAAAAAAAA;
      for (int i = 0; i < 4; i++) begin
         w = exp_win(1, 1);
         e = (w == 0) ? model_alu(ReqOp0, ReqA0, ReqB0) : model_alu(ReqOp1, ReqA1, ReqB1);
         run_txn(1, 1, 1, 0, gid, r, z, id, tmo);
         checks++;
         if (tmo || gid != w || r !== e[31:0] || z !== e[32] || id !== w[0]) begin
            errors++;
            $display("FAIL rr_%0d: got gnt%0d %h z%b id%b required gnt%0d %h z%b", i, gid, r,
                     z, id, w, e[31:0], e[32]);
         end
         last_win = w;
      end
      ReqValid0 = 0; ReqValid1 = 0;
   endtask

   task automatic test_backpressure;
      int gid, w; logic [32:0] e; bit seen;
      gid = -1; seen = 0;
      @(posedge Clock); #1;
      ReqOp0 = 2'b00; ReqA0 = $urandom; ReqB0 = $urandom;
      ReqOp1 = 2'b10; ReqA1 = $urandom; ReqB1 = $urandom;
      ReqValid0 = 1; ReqValid1 = 1; ResultReady = 0;
      w = exp_win(1, 1);
      e = (w == 0) ? model_alu(ReqOp0, ReqA0, ReqB0) : model_alu(ReqOp1, ReqA1, ReqB1);
      for (int i = 0; i < 8 && gid < 0; i++) begin
         @(negedge Clock);
         if (ReqReady0) gid = 0;
         else if (ReqReady1) gid = 1;
      end
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge Clock);
         seen = ResultValid;
      end
      checks++;
      if (!seen || gid != w || Result !== e[31:0] || ResultId !== w[0]) begin
         errors++;
         $display("FAIL bp_first: got gnt%0d v%b %h id%b required gnt%0d %h", gid, seen,
                  Result, ResultId, w, e[31:0]);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         checks++;
         if (ResultValid !== 1 || Result !== e[31:0] || ResultId !== w[0] ||
             ReqReady0 !== 0 || ReqReady1 !== 0) begin
            errors++;
            $display("FAIL bp_hold_%0d: got v%b %h id%b rdy%b%b required v1 %h id%0d rdy00",
                     i, ResultValid, Result, ResultId, ReqReady0, ReqReady1, e[31:0], w);
         end
      end
      ResultReady = 1; ReqValid0 = 0; ReqValid1 = 0;
      @(negedge Clock);
      checks++;
      if (ResultValid !== 0 || Busy !== 0) begin
         errors++; $display("FAIL bp_accept: got v%b busy%b required 00", ResultValid, Busy);
      end
      last_win = w;
   endtask

   task automatic test_wrap_op11;
      int gid; logic [31:0] r; logic z, id; bit tmo;
      ReqOp0 = 2'b00; ReqA0 = 32'hFFFFFFFF; ReqB0 = 32'd1;
      run_txn(1, 0, 0, 0, gid, r, z, id, tmo);
      checks++;
      if (tmo || gid != 0 || r !== 32'd0 || z !== 0 || id !== 0) begin
         errors++; $display("FAIL wrap_add: got %h z%b tmo%b required 00000000 z0", r, z, tmo);
      end
      ReqOp0 = 2'b11; ReqA0 = 32'd3; ReqB0 = 32'd1;
      run_txn(1, 0, 0, 0, gid, r, z, id, tmo);
      checks++;
      if (tmo || gid != 0 || r !== 32'd2 || z !== 0) begin
         errors++; $display("FAIL op11_xor: got %h z%b tmo%b required 00000002 z0", r, z, tmo);
      end
      last_win = 0;
   endtask

   task automatic test_reset_mid;
      @(posedge Clock); #1;
      ReqOp0 = 2'b00; ReqA0 = 32'd7; ReqB0 = 32'd9; ReqValid0 = 1; ResultReady = 1;
      @(negedge Clock);
      @(posedge Clock); #1;
      ReqValid0 = 0;
      ResetN = 0;
      #1;
      checks++;
      if (Busy !== 0 || ResultValid !== 0 || Result !== 32'd0 || ResultId !== 0 ||
          ResultZero !== 0 || ReqReady0 !== 0) begin
         errors++;
         $display("FAIL reset_mid: got busy%b v%b %h id%b z%b required all 0", Busy,
                  ResultValid, Result, ResultId, ResultZero);
      end
`ifdef ALU_ARB_STATS_EN
      checks++;
      if (GrantCount0 !== 16'd0 || GrantCount1 !== 16'd0) begin
         errors++; $display("FAIL reset_mid_counts: got %h %h required 0", GrantCount0,
                            GrantCount1);
      end
`endif
      @(negedge Clock);
      ResetN = 1;
      last_win = 1;
      ng0 = 0; ng1 = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         checks++;
         if (ResultValid !== 0) begin
            errors++; $display("FAIL reset_mid_nopulse_%0d: got v%b required 0", i, ResultValid);
         end
      end
   endtask

   task automatic test_random;
      int gid, w; logic [31:0] r; logic z, id; bit tmo, v0, v1; logic [32:0] e;
      for (int i = 0; i < 30; i++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         if (!v0 && !v1) v0 = 1;
         ReqOp0 = 2'($urandom_range(0, 3)); ReqB0 = $urandom;
         ReqA0 = ($urandom_range(0, 3) == 0) ? ReqB0 : $urandom;
         ReqOp1 = 2'($urandom_range(0, 3)); ReqB1 = $urandom;
         ReqA1 = ($urandom_range(0, 3) == 0) ? ReqB1 : $urandom;
         w = exp_win(v0, v1);
         e = (w == 0) ? model_alu(ReqOp0, ReqA0, ReqB0) : model_alu(ReqOp1, ReqA1, ReqB1);
         run_txn(v0, v1, 0, int'($urandom_range(0, 3)), gid, r, z, id, tmo);
         checks++;
         if (tmo || gid != w || r !== e[31:0] || z !== e[32] || id !== w[0]) begin
            errors++;
            $display("FAIL rand_%0d: got gnt%0d %h z%b id%b tmo%b required gnt%0d %h z%b", i,
                     gid, r, z, id, tmo, w, e[31:0], e[32]);
         end
         last_win = w;
         if (w == 0) ng0++;
         else ng1++;
         ReqValid0 = 0; ReqValid1 = 0;
      end
   endtask

`ifdef ALU_ARB_STATS_EN
   task automatic test_stats;
      @(negedge Clock);
      checks++;
      if (GrantCount0 !== 16'(ng0) || GrantCount1 !== 16'(ng1)) begin
         errors++;
         $display("FAIL grant_counts: got %0d %0d required %0d %0d", GrantCount0, GrantCount1,
                  ng0, ng1);
      end
   endtask
`endif

   initial begin
      ng0 = 0; ng1 = 0;
      test_reset();
      test_req0_add();
      test_req1_sub();
      test_both_rr();
      test_backpressure();
      test_wrap_op11();
      test_reset_mid();
      test_random();
`ifdef ALU_ARB_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
